// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_BUSY,
    MC_DONE
  } mc_state_e;

  typedef logic [31:0]      aes_col_t;
  typedef logic [3:0][31:0] aes_state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] aes_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers up to 15 collapse to a few XORs after synthesis.
  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = 8'h00;
    pow = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ pow;
      pow = aes_xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// One 32-bit column of MixColumns (forward) or InvMixColumns (inverse).
module aes_mix_single_column
  import aes_pkg::*;
(
  input  logic        mode_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [3:0][7:0] w_a;
  assign w_a = data_i;

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    logic [7:0] w_fwd;
    logic [7:0] w_inv;

    assign w_fwd = aes_gf_mul(w_a[r], 4'd2) ^ aes_gf_mul(w_a[R1], 4'd3) ^ w_a[R2] ^ w_a[R3];
    assign w_inv = aes_gf_mul(w_a[r], 4'd14) ^ aes_gf_mul(w_a[R1], 4'd11) ^
                   aes_gf_mul(w_a[R2], 4'd13) ^ aes_gf_mul(w_a[R3], 4'd9);

    assign data_o[8*r +: 8] = (mode_i == CIPH_INV) ? w_inv : w_fwd;
  end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns: NumColPar columns per cycle, mixed in place
// in a single 128-bit state register, with valid/ready handshakes on both sides.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NumColPar = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         mode_i,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  localparam int         NumIter = 4 / NumColPar;
  localparam logic [1:0] LastCol = 2'(NumIter - 1);

  if (!(NumColPar == 1 || NumColPar == 2 || NumColPar == 4)) begin : g_param_check
    $error("aes_mix_columns_iter: NumColPar must be 1, 2 or 4");
  end

  mc_state_e  r_fsm;
  logic [1:0] r_col;
  aes_state_t r_state;
  ciph_op_e   r_mode;

  logic                        w_accept;
  logic [1:0]                  w_base;
  logic [NumColPar-1:0][1:0]   w_col_idx;
  logic [NumColPar-1:0][31:0]  w_col_out;
  aes_state_t                  w_state_mixed;

  // A waiting result may be consumed and replaced by a new block in the same cycle.
  assign in_ready_o  = (r_fsm == MC_IDLE) | ((r_fsm == MC_DONE) & out_ready_i);
  assign w_accept    = in_valid_i & in_ready_o;
  assign out_valid_o = (r_fsm == MC_DONE);
  assign data_o      = r_state;

  assign w_base = 2'(NumColPar * int'(r_col));

  for (genvar k = 0; k < NumColPar; k++) begin : g_col
    assign w_col_idx[k] = w_base + 2'(k);

    aes_mix_single_column u_mix_col (
      .mode_i (r_mode),
      .data_i (r_state[w_col_idx[k]]),
      .data_o (w_col_out[k])
    );
  end

  always_comb begin
    // NOTE: start from the unmodified state so every path assigns it and no latch is inferred.
    w_state_mixed = r_state;
    for (int k = 0; k < NumColPar; k++) begin
      w_state_mixed[w_col_idx[k]] = w_col_out[k];
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= MC_IDLE;
      r_col   <= 2'd0;
      r_state <= '0;
      r_mode  <= CIPH_FWD;
    end else if (clear_i) begin
      r_fsm   <= MC_IDLE;
      r_col   <= 2'd0;
      r_state <= '0;
    end else if (w_accept) begin
      r_fsm   <= MC_BUSY;
      r_col   <= 2'd0;
      r_state <= data_i;
      r_mode  <= ciph_op_e'(mode_i);
    end else begin
      case (r_fsm)
        MC_BUSY: begin
          r_state <= w_state_mixed;
          if (r_col == LastCol) begin
            r_col <= 2'd0;
            r_fsm <= MC_DONE;
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        MC_DONE: begin
          if (out_ready_i) r_fsm <= MC_IDLE;
        end
        default: r_fsm <= r_fsm;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Bench for aes_mix_columns_iter: three instances (NumColPar 1, 2, 4), each watched by a
// transaction-level model; directed vectors carry hand-computed results.
module tb_aes_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n     [3];
  logic         clear     [3];
  logic         in_valid  [3];
  logic         mode      [3];
  logic         out_ready [3];
  logic [127:0] din       [3];
  wire          in_ready  [3];
  wire          out_valid [3];
  wire  [127:0] dout      [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int ncp(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  // Russian-peasant GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Column-wise product with the circulant (Inv)MixColumns matrix.
  function automatic logic [127:0] mix_ref(input logic inv, input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NCP = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

    aes_mix_columns_iter #(.NumColPar(NCP)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n[gi]),
      .clear_i     (clear[gi]),
      .in_valid_i  (in_valid[gi]),
      .in_ready_o  (in_ready[gi]),
      .mode_i      (mode[gi]),
      .data_i      (din[gi]),
      .out_valid_o (out_valid[gi]),
      .out_ready_i (out_ready[gi]),
      .data_o      (dout[gi])
    );

    // Model: cycles left until the result appears, whether a result is waiting,
    // and the value data_o must show when it is defined.
    initial begin
      int           busy_left;
      bit           ready;
      bit           known;
      logic [127:0] known_val;
      logic [127:0] result;
      bit           exp_in_ready;
      busy_left = 0; ready = 0; known = 1; known_val = '0; result = '0;
      forever begin
        @(negedge clk);
        if (!rst_n[gi]) begin
          check($sformatf("i%0d_rst_out_valid", gi), 128'(out_valid[gi]), 128'(0));
          check($sformatf("i%0d_rst_in_ready", gi), 128'(in_ready[gi]), 128'(1));
          check($sformatf("i%0d_rst_data", gi), dout[gi], '0);
          busy_left = 0; ready = 0; known = 1; known_val = '0;
        end else begin
          exp_in_ready = (busy_left == 0) && (!ready || out_ready[gi]);
          check($sformatf("i%0d_out_valid", gi), 128'(out_valid[gi]), 128'(ready));
          check($sformatf("i%0d_in_ready", gi), 128'(in_ready[gi]), 128'(exp_in_ready));
          if (known) check($sformatf("i%0d_data_o", gi), dout[gi], known_val);
          if (clear[gi]) begin
            busy_left = 0; ready = 0; known = 1; known_val = '0;
          end else if (in_valid[gi] && exp_in_ready) begin
            result    = mix_ref(mode[gi], din[gi]);
            busy_left = 4 / NCP;
            ready     = 0;
            known     = 0;
          end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
              ready = 1; known = 1; known_val = result;
            end
          end else if (ready && out_ready[gi]) begin
            ready = 0;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int i, input logic m, input logic [127:0] d);
    int cnt;
    cnt = 0;
    in_valid[i] = 1'b1;
    mode[i]     = m;
    din[i]      = d;
    while (1) begin
      @(negedge clk);
      if (in_ready[i]) break;
      cnt++;
      if (cnt > 100) begin
        check($sformatf("i%0d_send_timeout", i), 128'(0), 128'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  // Latency = negedges seen after the accepting edge before out_valid is high.
  task automatic recv(input int i, input string name, input logic [127:0] exp,
                      output logic [127:0] got, output int lat);
    out_ready[i] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid[i]) break;
      lat++;
      if (lat > 100) begin
        check($sformatf("i%0d_%s_timeout", i, name), 128'(0), 128'(1));
        break;
      end
    end
    got = dout[i];
    check($sformatf("i%0d_%s", i, name), got, exp);
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t1_in, t1_out, t2_in, t2_out, t3_in, t3_out;
    logic [127:0] got, got2, d, exp_bp;
    int           lat;

    t1_in  = {96'h0, 32'h455313db};
    t1_out = {96'h0, 32'hbca14d8e};
    t2_in  = {4{32'hbca14d8e}};
    t2_out = {4{32'h455313db}};
    t3_in  = {32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 32'hd5d4d4d4};
    t3_out = {32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, 32'hd6d7d5d5};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; clear[i] = 1'b0; in_valid[i] = 1'b0;
      mode[i] = 1'b0; out_ready[i] = 1'b0; din[i] = '0;
    end

    check("model_fwd_t1", mix_ref(1'b0, t1_in), t1_out);
    check("model_inv_t2", mix_ref(1'b1, t2_in), t2_out);
    check("model_fwd_t3", mix_ref(1'b0, t3_in), t3_out);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d_reset_valid", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("i%0d_reset_data", i), dout[i], '0);
      check($sformatf("i%0d_reset_in_ready", i), 128'(in_ready[i]), 128'(1));
      rst_n[i] = 1'b1;
    end
    @(posedge clk);
    #1;

    send(0, 1'b0, t1_in);
    recv(0, "t1_fwd", t1_out, got, lat);
    check("t1_latency", 128'(lat), 128'(4));
    send(0, 1'b1, t2_in);
    recv(0, "t2_inv", t2_out, got, lat);

    for (int i = 0; i < 3; i++) begin
      send(i, 1'b0, t3_in);
      recv(i, "t3_fwd", t3_out, got, lat);
      check($sformatf("i%0d_t3_latency", i), 128'(lat), 128'(4 / ncp(i)));
    end

    for (int i = 0; i < 3; i++) begin
      repeat (2) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        send(i, 1'b0, d);
        recv(i, "rt_fwd", mix_ref(1'b0, d), got, lat);
        send(i, 1'b1, got);
        recv(i, "rt_inv", d, got2, lat);
      end
    end

    // Backpressure: hold the result, then swap it for a new block in one cycle.
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_bp = mix_ref(1'b0, d);
    send(0, 1'b0, d);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_data", dout[0], exp_bp);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid[0] = 1'b1; mode[0] = 1'b1; din[0] = d; out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_swap_in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk);
    check("bp_swap_busy", 128'(out_valid[0]), 128'(0));
    @(posedge clk);
    #1;
    recv(0, "bp_second", mix_ref(1'b1, d), got, lat);

    // Synchronous clear during BUSY cycle 2.
    send(0, 1'b0, t3_in);
    @(posedge clk);
    #1;
    clear[0] = 1'b1;
    @(posedge clk);
    #1;
    clear[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("clr_valid", 128'(out_valid[0]), 128'(0));
      check("clr_data", dout[0], '0);
      check("clr_in_ready", 128'(in_ready[0]), 128'(1));
    end
    @(posedge clk);
    #1;
    send(0, 1'b0, t1_in);
    recv(0, "clr_after", t1_out, got, lat);

    // Asynchronous reset in the middle of BUSY.
    send(0, 1'b0, t3_in);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid[0]), 128'(0));
    check("arst_data", dout[0], '0);
    check("arst_in_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    send(0, 1'b0, t3_in);
    recv(0, "arst_after", t3_out, got, lat);

    // Inputs wander during BUSY; the result must follow the accepted values.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(0, 1'b1, d);
    for (int k = 0; k < 3; k++) begin
      mode[0] = ~mode[0];
      din[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    recv(0, "toggle_inv", mix_ref(1'b1, d), got, lat);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
